// File: rtl/register_dump_streamer.sv
// rtl/register_dump_streamer.sv - snapshot 32 registers and stream them as a framed, checksummed byte sequence
module register_dump_streamer #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         NUM_REGS  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] regs [0:NUM_REGS-1],
  output logic        busy,
  output logic        done,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    IDX,
    DATA,
    CSUM
  } state_t;

  localparam logic [4:0] LAST_REG = 5'(NUM_REGS - 1);

  state_t      state, state_next;
  logic [4:0]  reg_idx, reg_idx_next;
  logic [1:0]  byte_idx, byte_idx_next;
  logic [7:0]  csum, csum_next;
  logic        done_next;
  logic        capture;
  logic        xfer;
  logic [31:0] snap [0:NUM_REGS-1];
  logic [31:0] cur_word;

  // A byte moves whenever one is presented and the sink takes it; in IDLE nothing is presented.
  assign xfer     = (state != IDLE) && tx_ready;
  assign cur_word = snap[reg_idx];

  // Snapshot buffer: loaded in the same edge that accepts start, never cleared.
  always_ff @(posedge clk) begin
    if (!reset && capture) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        snap[i] <= regs[i];
      end
    end
  end

  // State, counters, checksum and the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      reg_idx  <= 5'd0;
      byte_idx <= 2'd0;
      csum     <= 8'h00;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      reg_idx  <= reg_idx_next;
      byte_idx <= byte_idx_next;
      csum     <= csum_next;
      done     <= done_next;
    end
  end

  // Next-state logic and the presented byte; tx_data is a function of state only, never of tx_ready.
  always_comb begin
    state_next    = state;
    reg_idx_next  = reg_idx;
    byte_idx_next = byte_idx;
    csum_next     = csum;
    done_next     = 1'b0;
    capture       = 1'b0;
    tx_valid      = 1'b0;
    tx_data       = 8'h00;
    busy          = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          capture       = 1'b1;
          state_next    = SYNC;
          reg_idx_next  = 5'd0;
          byte_idx_next = 2'd0;
          csum_next     = 8'h00;
        end
      end
      SYNC: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = SYNC_BYTE;
        if (xfer) begin
          state_next = IDX;
        end
      end
      IDX: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = {3'b000, reg_idx};
        if (xfer) begin
          csum_next     = csum ^ tx_data;
          byte_idx_next = 2'd0;
          state_next    = DATA;
        end
      end
      DATA: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        case (byte_idx)
          2'd0:    tx_data = cur_word[31:24];
          2'd1:    tx_data = cur_word[23:16];
          2'd2:    tx_data = cur_word[15:8];
          default: tx_data = cur_word[7:0];
        endcase
        if (xfer) begin
          csum_next = csum ^ tx_data;
          if (byte_idx != 2'd3) begin
            byte_idx_next = byte_idx + 2'd1;
          end else if (reg_idx != LAST_REG) begin
            reg_idx_next = reg_idx + 5'd1;
            state_next   = IDX;
          end else begin
            state_next = CSUM;
          end
        end
      end
      CSUM: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = csum;
        if (xfer) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_register_dump_streamer.sv
// tb/tb_register_dump_streamer.sv - randomized self-checking bench for register_dump_streamer
module tb_register_dump_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] regs [0:31];
  logic        busy;
  logic        done;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int n_checks = 0;
  int n_fail   = 0;

  register_dump_streamer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .regs     (regs),
    .busy     (busy),
    .done     (done),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
  endtask

  // Drives one frame and checks every byte against the reference frame built from regs.
  // rand_ready: ~50% tx_ready; clobber: overwrite regs and pulse start during the frame;
  // abort_at: reset right after that many bytes transfer (0 = never); skip_start: start was
  // already raised by the previous call; chain: raise start in the done cycle.
  task automatic run_frame(input bit rand_ready, input bit clobber, input int abort_at,
                           input bit skip_start, input bit chain);
    logic [7:0] exp_q[$];
    logic [7:0] cs;
    logic [7:0] stall_data;
    int         idx, busy_cycles, last_xfer;
    bit         stall, finished;

    exp_q.push_back(8'hA5);
    cs = 8'h00;
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(8'(i));
      cs ^= 8'(i);
      for (int b = 3; b >= 0; b--) begin
        exp_q.push_back(regs[i][8*b +: 8]);
        cs ^= regs[i][8*b +: 8];
      end
    end
    exp_q.push_back(cs);

    if (!skip_start) begin
      @(posedge clk); #1;
      start = 1'b1;
    end
    @(posedge clk); #1;
    start    = 1'b0;
    tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (clobber) for (int i = 0; i < 32; i++) regs[i] = 32'hFFFFFFFF;

    idx = 0; busy_cycles = 0; last_xfer = -10; stall = 0; finished = 0; stall_data = 8'h00;
    for (int cyc = 0; cyc < 1000 && !finished; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        check("first_valid", 32'(tx_valid), 32'd1);
        check("first_busy", 32'(busy), 32'd1);
        check("first_byte", 32'(tx_data), 32'hA5);
      end
      if (stall) begin
        check("stall_valid", 32'(tx_valid), 32'd1);
        check("stall_data", 32'(tx_data), 32'(stall_data));
      end
      stall      = tx_valid && !tx_ready;
      stall_data = tx_data;
      if (busy) busy_cycles++;
      if (done) begin
        finished = 1;
        check("frame_len", 32'(idx), 32'd162);
        check("done_timing", 32'(cyc), 32'(last_xfer + 1));
        check("done_valid", 32'(tx_valid), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        check("busy_cycles", 32'(busy_cycles), 32'(cyc));
        if (!rand_ready) check("done_cycle", 32'(cyc), 32'd162);
        if (chain) start = 1'b1;
      end else if (tx_valid && tx_ready) begin
        if (idx < 162) check("frame_byte", 32'(tx_data), 32'(exp_q[idx]));
        else           check("extra_byte", 32'(idx), 32'd161);
        idx++;
        last_xfer = cyc;
        if (abort_at > 0 && idx == abort_at) begin
          @(posedge clk); #1;
          reset = 1'b1;
          @(posedge clk); #1;
          reset = 1'b0;
          @(negedge clk);
          check("abort_valid", 32'(tx_valid), 32'd0);
          check("abort_busy", 32'(busy), 32'd0);
          check("abort_done", 32'(done), 32'd0);
          repeat (3) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
            check("abort_idle", 32'(tx_valid), 32'd0);
          end
          return;
        end
      end
      if (!finished) begin
        @(posedge clk); #1;
        if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
        if (clobber) start = (idx < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    if (!finished) check("frame_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    tx_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_valid", 32'(tx_valid), 32'd0);
    check("reset_data", 32'(tx_data), 32'h00);
    @(posedge clk); #1;
    reset    = 1'b0;
    tx_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_valid", 32'(tx_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end

    for (int i = 0; i < 32; i++) regs[i] = i * 32'h01010101;
    run_frame(0, 0, 0, 0, 0);

    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[5] = 32'hDEADBEEF;
    run_frame(0, 0, 0, 0, 0);

    fill_random();
    run_frame(1, 0, 0, 0, 0);

    fill_random();
    run_frame(0, 1, 0, 0, 0);

    fill_random();
    run_frame(1, 0, 50, 0, 0);
    run_frame(0, 0, 0, 0, 0);

    fill_random();
    run_frame(0, 0, 0, 0, 1);
    run_frame(1, 0, 0, 1, 0);

    @(posedge clk); #1;
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("reset_over_start_busy", 32'(busy), 32'd0);
    check("reset_over_start_valid", 32'(tx_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_dump_streamer.md
# register_dump_streamer

Debug read-out engine for the register file's exported register view. On a start pulse it snapshots all 32 architectural registers in one cycle. It then streams them as a framed byte sequence over a valid/ready byte interface. The interface feeds the board-level debug transmitter (UART/JTAG bridge), so the host can inspect CPU state without halting the core.

## Interface
Parameters:
- SYNC_BYTE, 8'hA5, first byte of every frame
- NUM_REGS, 32, registers captured per frame; fixed at 32 for this design, index byte is 5 bits zero-extended

Ports:
- clk  input  1  clock, rising-edge
- reset  input  1  reset, synchronous, active-high
- start  input  1  request a dump; sampled on rising edge, acted on only in IDLE
- regs  input  32 x 32  unpacked array, live register-file contents (regs[0]..regs[31])
- busy  output  1  high from the cycle after start is accepted until the frame completes
- done  output  1  one-cycle pulse after the checksum byte is accepted
- tx_data  output  8  current frame byte
- tx_valid  output  1  tx_data is valid
- tx_ready  input  1  downstream accepts tx_data this cycle

## Operation
- Frame format, 162 bytes:
  - SYNC_BYTE.
  - Then, for i = 0..31: index byte {3'b000, i[4:0]}, followed by regs[i][31:24], [23:16], [15:8], [7:0] (MSB first).
  - Then a checksum byte.
- Checksum is the XOR of every index byte and data byte. SYNC_BYTE is excluded.
- Snapshot: at the edge where start is accepted, all 32 words are copied into an internal 32x32 buffer. Later changes on regs do not affect the frame in progress.
- FSM states and transitions:
  - IDLE: start=1 -> SYNC, capture snapshot, clear checksum, reg_idx=0.
  - SYNC: on transfer -> IDX.
  - IDX: on transfer -> DATA, byte_idx=0.
  - DATA: on transfer, byte_idx 0..2 -> byte_idx+1. On transfer with byte_idx=3: reg_idx<31 -> IDX with reg_idx+1; reg_idx=31 -> CSUM.
  - CSUM: on transfer -> IDLE.
- A transfer occurs on any rising edge where tx_valid=1 and tx_ready=1.
- The checksum accumulator XORs in each IDX/DATA byte at its transfer edge.
- start is ignored while busy. There is no queueing and no restart.
- Reset values: state=IDLE, busy=0, done=0, tx_valid=0, tx_data=8'h00, counters=0, checksum=0. The snapshot buffer is not reset.

## Timing
- Start accepted at edge N -> busy=1, tx_valid=1 and tx_data=SYNC_BYTE during cycle N+1.
- Handshake:
  - Once tx_valid is high, tx_data and tx_valid hold stable until a transfer occurs.
  - tx_valid never drops without a transfer, except on reset.
  - tx_data must not depend combinationally on tx_ready.
- Throughput is one byte per cycle when tx_ready is held high. The next byte is presented in the cycle after a transfer.
- With tx_ready constantly 1, a full frame takes 162 cycles, N+1..N+162.
- At the checksum transfer edge M:
  - During cycle M+1: tx_valid=0, busy=0, done=1.
  - done is 0 again in cycle M+2.
  - A start sampled at edge M+1 is accepted, giving back-to-back frames with a one-cycle gap.
- Reset mid-frame: at the reset edge the frame is abandoned. In the next cycle tx_valid=0, busy=0, done=0. No checksum is emitted.
- Reset has priority over start sampled on the same edge.
- tx_ready while tx_valid=0 has no effect.

## Test plan
- regs[i]=i*32'h01010101, start pulse, tx_ready=1 -> 162 consecutive bytes: A5, 00 00 00 00 00, 01 01 01 01 01, ..., 1F 1F 1F 1F 1F, checksum 00; done pulses in cycle N+163; busy is high for exactly 162 cycles.
- All regs zero except regs[5]=32'hDEADBEEF -> the bytes for reg 5 are 05 DE AD BE EF; the checksum is 8'h22.
- Random tx_ready (~50% duty) -> the byte sequence is identical to the tx_ready=1 run; tx_data and tx_valid are stable across every stall cycle; frame length is 162.
- After start, overwrite every regs[i] with 32'hFFFFFFFF -> the frame still carries the pre-start values; start pulses issued while busy produce no extra bytes.
- Assert reset for one cycle after byte 50 is transferred -> next cycle tx_valid=0, busy=0, and no done pulse; a subsequent start yields a complete, correct 162-byte frame beginning with A5.
- Pulse start in the done cycle -> the second frame's SYNC byte appears two cycles after the first frame's checksum transfer.
